jtdd_vram_arb: RTL

JTDD_VRAM_ARB -- requirements
Module: jtdd_vram_arb

---
 rtl/jtdd_vram_pkg.sv | 16 +
 rtl/jtdd_vram_wdog.sv | 39 +++
 rtl/jtdd_vram_arb.sv | 115 +++++++++++
 3 files changed

// File: rtl/jtdd_vram_pkg.sv
// Shared definitions for the JTDD video RAM arbiter: state encoding, slot masks and
// the default watchdog limit.
package jtdd_vram_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StCpuAcc = 2'd1,
    StVidAcc = 2'd2,
    StDone   = 2'd3
  } vram_state_e;

  localparam logic [5:0]  VID_SLOTS    = 6'b010101;
  localparam logic [5:0]  CPU_SLOTS    = 6'b101010;
  localparam int unsigned WD_LIMIT_DEF = 64;

endpackage

// File: rtl/jtdd_vram_wdog.sv
// CPU starvation watchdog: counts CPU-eligible slots while a request is pending and
// pulses err once the count reaches LIMIT.
module jtdd_vram_wdog
  import jtdd_vram_pkg::*;
#(
  parameter int unsigned LIMIT = WD_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  input  logic pending,
  input  logic ack,
  output logic err
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err   <= 1'b0;
    end else begin
      err <= 1'b0;
      if (ack) begin
        cnt_q <= '0;
      end else if (tick && pending) begin
        if (cnt_q == CW'(LIMIT - 1)) begin
          cnt_q <= '0;
          err   <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/jtdd_vram_arb.sv
// Slot-based CPU/video arbiter for a synchronous VRAM. Optional watchdog enabled by
// defining JTDD_VRAM_WATCHDOG_EN.
module jtdd_vram_arb
  import jtdd_vram_pkg::*;
#(
  parameter int unsigned AW       = 13,
  parameter int unsigned DW       = 8,
  parameter int unsigned WD_LIMIT = WD_LIMIT_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pxl_cen,
  input  logic [5:0]    M,
  input  logic          HBL,
  input  logic          VBL,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_ack,
  output logic          cpu_wait,
  output logic          cpu_err,
  input  logic [AW-1:0] vid_addr,
  output logic [DW-1:0] vid_data,
  output logic          vid_valid,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata
);

  vram_state_e state_q;
  logic        acc_cpu_q;
  logic        acc_wr_q;

  logic slot_ev, vid_slot, cpu_slot, blank, cpu_elig, cpu_block;

  // Hook held low in normal operation; lets a bench starve the CPU of grants.
  assign cpu_block = 1'b0;

  assign slot_ev  = pxl_cen && (M != 6'd0);
  assign vid_slot = |(M & VID_SLOTS);
  assign cpu_slot = |(M & CPU_SLOTS);
  assign blank    = HBL || VBL;
  assign cpu_elig = cpu_slot || (vid_slot && blank);
  assign cpu_wait = cpu_req && !cpu_ack;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      acc_cpu_q <= 1'b0;
      acc_wr_q  <= 1'b0;
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      cpu_rdata <= '0;
      cpu_ack   <= 1'b0;
      vid_data  <= '0;
      vid_valid <= 1'b0;
    end else begin
      ram_we    <= 1'b0;
      cpu_ack   <= 1'b0;
      vid_valid <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (slot_ev) begin
            if (vid_slot && !blank) begin
              state_q   <= StVidAcc;
              ram_addr  <= vid_addr;
              acc_cpu_q <= 1'b0;
              acc_wr_q  <= 1'b0;
            end else if (cpu_elig && cpu_req && !cpu_ack && !cpu_block) begin
              // cpu_ack masks the still-high request of the access just finished
              state_q   <= StCpuAcc;
              ram_addr  <= cpu_addr;
              ram_we    <= cpu_we;
              ram_wdata <= cpu_wdata;
              acc_cpu_q <= 1'b1;
              acc_wr_q  <= cpu_we;
            end
          end
        end
        StCpuAcc, StVidAcc: state_q <= StDone;
        StDone: begin
          state_q <= StIdle;
          if (acc_cpu_q) begin
            cpu_ack <= 1'b1;
            if (!acc_wr_q) cpu_rdata <= ram_rdata;
          end else begin
            vid_valid <= 1'b1;
            vid_data  <= ram_rdata;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef JTDD_VRAM_WATCHDOG_EN
  jtdd_vram_wdog #(
    .LIMIT (WD_LIMIT)
  ) u_wdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (slot_ev && cpu_elig),
    .pending (cpu_wait),
    .ack     (cpu_ack),
    .err     (cpu_err)
  );
`else
  assign cpu_err = 1'b0;
`endif

endmodule
